// File: rtl/onewire_xfer.sv
// onewire_xfer: 1-Wire master bit-slot engine, LSB-first write/read of 0..MAX_BITS bits.
// Define OW_STRONG_PULLUP_EN to add the strong_pu output and the post-write SPU hold state.
module onewire_xfer #(
  parameter int unsigned CLK_MHZ   = 27,
  parameter int unsigned MAX_BITS  = 64,
  parameter int unsigned T_W1L_US  = 6,
  parameter int unsigned T_W0L_US  = 60,
  parameter int unsigned T_RL_US   = 6,
  parameter int unsigned T_MSR_US  = 15,
  parameter int unsigned T_SLOT_US = 70,
  parameter int unsigned SPU_US    = 500
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          mode,
  input  logic [$clog2(MAX_BITS+1)-1:0] nbits,
  input  logic [MAX_BITS-1:0]           wdata,
  input  logic                          bus_in,
  output logic                          busy,
  output logic                          done,
  output logic [MAX_BITS-1:0]           rdata,
`ifdef OW_STRONG_PULLUP_EN
  output logic                          strong_pu,
`endif
  output logic                          drive_low
);

  localparam int unsigned NbW     = $clog2(MAX_BITS + 1);
  localparam int unsigned IdxW    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int unsigned SlotCyc = T_SLOT_US * CLK_MHZ;
  localparam int unsigned CntW    = $clog2(SlotCyc);

  localparam logic [CntW-1:0] Low1     = CntW'(T_W1L_US * CLK_MHZ);
  localparam logic [CntW-1:0] Low0     = CntW'(T_W0L_US * CLK_MHZ);
  localparam logic [CntW-1:0] LowR     = CntW'(T_RL_US * CLK_MHZ);
  localparam logic [CntW-1:0] MsrLast  = CntW'(T_MSR_US * CLK_MHZ - 1);
  localparam logic [CntW-1:0] SlotLast = CntW'(SlotCyc - 1);
  localparam logic [NbW-1:0]  MaxBitsN = NbW'(MAX_BITS);

`ifdef OW_STRONG_PULLUP_EN
  localparam int unsigned     SpuCyc  = SPU_US * CLK_MHZ;
  localparam int unsigned     SpuW    = (SpuCyc > 1) ? $clog2(SpuCyc) : 1;
  localparam logic [SpuW-1:0] SpuLast = SpuW'(SpuCyc - 1);
`endif

  typedef enum logic [1:0] {
    StIdle,
    StSlot,
    StFinish
`ifdef OW_STRONG_PULLUP_EN
    , StSpu
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     bit_idx_q, bit_idx_d;
  logic                mode_q, mode_d;
  logic [NbW-1:0]      nbits_q, nbits_d;
  logic [MAX_BITS-1:0] wdata_q, wdata_d;
  logic [MAX_BITS-1:0] rdata_q, rdata_d;
  logic                drive_low_q, drive_low_d;
  logic [CntW-1:0]     low_d;
  logic [IdxW-1:0]     last_idx;
  logic                bus_meta_q, bus_s;
`ifdef OW_STRONG_PULLUP_EN
  logic [SpuW-1:0]     spu_cnt_q, spu_cnt_d;
`endif

  // Idle bus reads high, so the synchroniser resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_meta_q <= 1'b1;
      bus_s      <= 1'b1;
    end else begin
      bus_meta_q <= bus_in;
      bus_s      <= bus_meta_q;
    end
  end

  assign last_idx = IdxW'(nbits_q - 1'b1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    mode_d    = mode_q;
    nbits_d   = nbits_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
`ifdef OW_STRONG_PULLUP_EN
    spu_cnt_d = spu_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d    = mode;
          wdata_d   = wdata;
          nbits_d   = (nbits > MaxBitsN) ? MaxBitsN : nbits;
          rdata_d   = '0;
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = (nbits == '0) ? StFinish : StSlot;
        end
      end
      StSlot: begin
        cnt_d = cnt_q + 1'b1;
        if (mode_q && (cnt_q == MsrLast)) begin
          rdata_d[bit_idx_q] = bus_s;
        end
        if (cnt_q == SlotLast) begin
          cnt_d = '0;
          if (bit_idx_q == last_idx) begin
`ifdef OW_STRONG_PULLUP_EN
            state_d   = mode_q ? StFinish : StSpu;
            spu_cnt_d = '0;
`else
            state_d = StFinish;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      StFinish: state_d = StIdle;
`ifdef OW_STRONG_PULLUP_EN
      StSpu: begin
        spu_cnt_d = spu_cnt_q + 1'b1;
        if (spu_cnt_q == SpuLast) begin
          state_d = StFinish;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // drive_low is registered from next-state values so it lines up with cnt.
  always_comb begin
    if (mode_d) begin
      low_d = LowR;
    end else if (wdata_d[bit_idx_d]) begin
      low_d = Low1;
    end else begin
      low_d = Low0;
    end
    drive_low_d = (state_d == StSlot) && (cnt_d < low_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      mode_q      <= 1'b0;
      nbits_q     <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      drive_low_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      mode_q      <= mode_d;
      nbits_q     <= nbits_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      drive_low_q <= drive_low_d;
    end
  end

`ifdef OW_STRONG_PULLUP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spu_cnt_q <= '0;
    end else begin
      spu_cnt_q <= spu_cnt_d;
    end
  end

  assign strong_pu = (state_q == StSpu);
  assign busy      = (state_q == StSlot) || (state_q == StSpu);
`else
  assign busy      = (state_q == StSlot);
`endif

  assign done      = (state_q == StFinish);
  assign rdata     = rdata_q;
  assign drive_low = drive_low_q;

endmodule

// File: tb/tb_onewire_xfer.sv
// tb_onewire_xfer: table-driven and randomized checks of onewire_xfer against a slot-timing model.
// Honours OW_STRONG_PULLUP_EN when the design is built with it.
module tb_onewire_xfer;

  localparam int unsigned ClkMhz  = 3;
  localparam int unsigned MaxBits = 16;
  localparam int unsigned NbW     = $clog2(MaxBits + 1);
  localparam int          SlotCyc = 70 * ClkMhz;
  localparam int          Low1Cyc = 6 * ClkMhz;
  localparam int          Low0Cyc = 60 * ClkMhz;
  localparam int          LowRCyc = 6 * ClkMhz;
  localparam int          MsrCyc  = 15 * ClkMhz;
`ifdef OW_STRONG_PULLUP_EN
  localparam int          SpuCyc  = 500 * ClkMhz;
`else
  localparam int          SpuCyc  = 0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               mode = 1'b0;
  logic [NbW-1:0]     nbits = '0;
  logic [MaxBits-1:0] wdata = '0;
  logic               bus_in;
  logic               busy, done, drive_low;
  logic [MaxBits-1:0] rdata;
  logic               slave_low = 1'b0;
`ifdef OW_STRONG_PULLUP_EN
  logic               strong_pu;
`endif

  int errors = 0;
  int checks = 0;

  assign bus_in = ~(drive_low | slave_low);
  always #5 clk = ~clk;

  onewire_xfer #(
    .CLK_MHZ (ClkMhz),
    .MAX_BITS(MaxBits)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .nbits    (nbits),
    .wdata    (wdata),
    .bus_in   (bus_in),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
`ifdef OW_STRONG_PULLUP_EN
    .strong_pu(strong_pu),
`endif
    .drive_low(drive_low)
  );

  typedef struct {
    logic               m;
    logic [NbW-1:0]     nb;
    logic [MaxBits-1:0] wd;
    logic [MaxBits-1:0] pat;
    int                 ign1;
    int                 ign2;
    int                 exp_done;
    logic [MaxBits-1:0] exp_rd;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int eff_bits(input logic [NbW-1:0] nb);
    return (int'(nb) > int'(MaxBits)) ? int'(MaxBits) : int'(nb);
  endfunction

  function automatic int model_done(input logic m, input logic [NbW-1:0] nb);
    int e = eff_bits(nb);
    return e * SlotCyc + ((!m && e > 0) ? SpuCyc : 0) + 1;
  endfunction

  function automatic logic [MaxBits-1:0] model_rdata(input logic m, input logic [NbW-1:0] nb,
                                                     input logic [MaxBits-1:0] pat);
    logic [MaxBits-1:0] r = '0;
    if (m) for (int i = 0; i < eff_bits(nb); i++) r[i] = pat[i];
    return r;
  endfunction

  function automatic int low_for(input logic m, input logic b);
    return m ? LowRCyc : (b ? Low1Cyc : Low0Cyc);
  endfunction

  // One transaction; cycle c counts from the accepting edge (c=1 is the first cycle after it).
  task automatic run_xfer(input logic m, input logic [NbW-1:0] nb, input logic [MaxBits-1:0] wd,
                          input logic [MaxBits-1:0] pat, input int ign1, input int ign2,
                          input int exp_done, input logic [MaxBits-1:0] exp_rd, input int id);
    int eff, spu, total, dl_bad, busy_bad, spu_bad, done_n, done_at, s, o;
    logic in_slot, exp_dl;
    logic [MaxBits-1:0] rd_at_done;
    eff = eff_bits(nb);
    spu = (!m && eff > 0) ? SpuCyc : 0;
    total = eff * SlotCyc + spu + 1;
    dl_bad = 0; busy_bad = 0; spu_bad = 0; done_n = 0; done_at = -1; rd_at_done = 'x;
    @(negedge clk);
    start = 1'b1; mode = m; nbits = nb; wdata = wd;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; nbits = NbW'($urandom()); wdata = MaxBits'($urandom());
    for (int c = 1; c <= total + 4; c++) begin
      in_slot = (c <= eff * SlotCyc);
      s = (c - 1) / SlotCyc;
      o = (c - 1) % SlotCyc;
      slave_low = 1'b0;
      exp_dl = 1'b0;
      if (in_slot) begin
        slave_low = m && !pat[s] && (o < MsrCyc + 10);
        exp_dl = (o < low_for(m, wd[s]));
      end
      #1;
      if (drive_low !== exp_dl) dl_bad++;
      if (busy !== (c < total)) busy_bad++;
`ifdef OW_STRONG_PULLUP_EN
      if (strong_pu !== (c > eff * SlotCyc && c <= eff * SlotCyc + spu)) spu_bad++;
`endif
      if (done === 1'b1) begin
        done_n++;
        if (done_at < 0) begin
          done_at = c;
          rd_at_done = rdata;
        end
      end
      if (c == ign1 || c == ign2) begin
        start = 1'b1; mode = 1'($urandom()); nbits = NbW'($urandom());
        wdata = MaxBits'($urandom());
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    slave_low = 1'b0;
    check($sformatf("x%0d drive_low bad cycles", id), 64'(dl_bad), 64'd0);
    check($sformatf("x%0d busy bad cycles", id), 64'(busy_bad), 64'd0);
    check($sformatf("x%0d strong_pu bad cycles", id), 64'(spu_bad), 64'd0);
    check($sformatf("x%0d done count", id), 64'(done_n), 64'd1);
    check($sformatf("x%0d done cycle", id), 64'(done_at), 64'(exp_done));
    check($sformatf("x%0d rdata at done", id), 64'(rd_at_done), 64'(exp_rd));
    check($sformatf("x%0d rdata held", id), 64'(rdata), 64'(exp_rd));
  endtask

  initial begin
    int dn;
    logic m;
    logic [NbW-1:0] nb;
    logic [MaxBits-1:0] wd, pat;

    tbl[0] = '{1'b0, NbW'(8),  16'h00A5, 16'h0000, 0,   0,    8 * SlotCyc + 1 + SpuCyc,  16'h0000};
    tbl[1] = '{1'b1, NbW'(8),  16'h00FF, 16'h003C, 0,   0,    8 * SlotCyc + 1,           16'h003C};
    tbl[2] = '{1'b0, NbW'(0),  16'hFFFF, 16'h0000, 0,   0,    1,                         16'h0000};
    tbl[3] = '{1'b0, NbW'(16), 16'hBEEF, 16'h0000, 500, 3000, 16 * SlotCyc + 1 + SpuCyc, 16'h0000};
    tbl[4] = '{1'b1, NbW'(20), 16'h1234, 16'h5A93, 0,   0,    16 * SlotCyc + 1,          16'h5A93};
    tbl[5] = '{1'b0, NbW'(3),  16'h0006, 16'hFFFF, 0,   0,    3 * SlotCyc + 1 + SpuCyc,  16'h0000};
    tbl[6] = '{1'b1, NbW'(0),  16'h0000, 16'h0000, 0,   0,    1,                         16'h0000};
    tbl[7] = '{1'b1, NbW'(1),  16'h0000, 16'hFFFF, 0,   0,    SlotCyc + 1,               16'h0001};

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset drive_low", 64'(drive_low), 64'd0);
    check("reset rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_xfer(tbl[i].m, tbl[i].nb, tbl[i].wd, tbl[i].pat, tbl[i].ign1, tbl[i].ign2,
               tbl[i].exp_done, tbl[i].exp_rd, i);
    end

    // Leave a read result behind, then reset 100 cycles into a write-0 slot.
    run_xfer(1'b1, NbW'(2), 16'h0, 16'h0002, 0, 0, 2 * SlotCyc + 1, 16'h0002, 8);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; nbits = NbW'(4); wdata = '0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #3;
    check("pre-reset drive_low", 64'(drive_low), 64'd1);
    check("pre-reset busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async reset drive_low", 64'(drive_low), 64'd0);
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset rdata", 64'(rdata), 64'd0);
    dn = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || drive_low !== 1'b0) dn++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || drive_low !== 1'b0) dn++;
    end
    check("no activity after reset", 64'(dn), 64'd0);
    run_xfer(1'b0, NbW'(2), 16'h0001, 16'h0, 0, 0, 2 * SlotCyc + 1 + SpuCyc, 16'h0, 9);

    for (int k = 0; k < 8; k++) begin
      m   = 1'($urandom_range(0, 1));
      nb  = NbW'($urandom_range(0, MaxBits + 3));
      wd  = MaxBits'($urandom());
      pat = MaxBits'($urandom());
      run_xfer(m, nb, wd, pat, 0, 0, model_done(m, nb), model_rdata(m, nb, pat), 10 + k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onewire_xfer.md
Name: onewire_xfer

Overview:
- Parametrised 1-Wire master bit-slot engine: performs a write or read transaction of 0..MAX_BITS bits, LSB first, one time slot per bit.
- Generalises the fixed 8-bit write-only engine: configurable clock rate, slot timings and transfer length, plus read slots with bus sampling.
- Sits between the command sequencer and the open-drain pad. drive_low=1 pulls the bus low; bus_in is the raw pad input.

Parameters:
- CLK_MHZ, 27, clock frequency in MHz; all timings are US*CLK_MHZ cycles.
- MAX_BITS, 64, maximum bits per transaction; width of wdata/rdata.
- T_W1L_US, 6, low time for write-1 slot.
- T_W0L_US, 60, low time for write-0 slot.
- T_RL_US, 6, low time for read slot.
- T_MSR_US, 15, read sample point from slot start.
- T_SLOT_US, 70, total slot length including recovery; must exceed T_W0L_US.
- SPU_US, 500, strong-pullup hold time (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; accepted only while busy=0
- mode  in  1  0=write, 1=read; sampled at accept
- nbits  in  $clog2(MAX_BITS+1)  bit count; sampled at accept
- wdata  in  MAX_BITS  write data, LSB sent first; sampled at accept
- bus_in  in  1  raw bus level, asynchronous to clk
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse at end of transaction
- rdata  out  MAX_BITS  read data, bit i = slot i
- drive_low  out  1  1 = pull bus low

Behaviour:
- Reset, asynchronous active-low:
  - busy=0, done=0, drive_low=0, rdata=0, state=IDLE, counters=0.
  - Reset asserted mid-slot releases the bus immediately and abandons the transaction. No done pulse is issued.
- Cycle constants:
  - LOW1=T_W1L_US*CLK_MHZ, LOW0=T_W0L_US*CLK_MHZ, LOWR=T_RL_US*CLK_MHZ, MSR=T_MSR_US*CLK_MHZ, SLOT=T_SLOT_US*CLK_MHZ.
  - Slot counter width is $clog2(SLOT).
- bus_in passes through a 2-flop synchroniser (bus_s) before any use.
- States: IDLE, SLOT, FINISH (plus SPU when the optional feature is compiled in).
- IDLE:
  - start=1 latches mode, wdata and nbits; rdata is cleared to 0.
  - nbits greater than MAX_BITS is clamped to MAX_BITS.
  - nbits=0: go to FINISH.
  - Otherwise go to SLOT with bit_idx=0 and cnt=0.
- SLOT:
  - cnt increments each cycle.
  - drive_low (registered) is 1 while cnt < LOW, where LOW = LOW1, LOW0 or LOWR by mode and current bit. It is 0 for the rest of the slot.
  - Read mode: at cnt==MSR-1, rdata[bit_idx] <= bus_s.
  - At cnt==SLOT-1: cnt<=0. If bit_idx==nbits-1, go to FINISH; else bit_idx increments.
- FINISH: done=1 for exactly one cycle, busy=0, return to IDLE. A new start is accepted on the following cycle.
- Latency: with start accepted at cycle 0, drive_low first rises at cycle 1, and done pulses at cycle nbits*SLOT+1 (cycle 1 for nbits=0).
- busy is high from cycle 1 until the done cycle, exclusive.
- start while busy=1 is ignored entirely and has no effect on the transaction in progress.
- rdata holds its value until the next accepted start. Write transactions leave rdata=0.
- drive_low is never high outside SLOT (or SPU).

Optional Feature:
- Macro: OW_STRONG_PULLUP_EN.
- Defined:
  - Adds output port strong_pu (1 bit, reset 0).
  - After the last slot of a write transaction with nbits>0, the engine enters state SPU instead of FINISH.
  - In SPU, strong_pu=1 and drive_low=0 for SPU_US*CLK_MHZ cycles, then FINISH. done is delayed accordingly and busy stays high.
  - Read transactions and nbits=0 never enter SPU.
- Not defined: no strong_pu port, no SPU state; timing as in Behaviour.

Test Plan:
- CLK_MHZ=27, write, nbits=8, wdata=0xA5 -> drive_low low pulses of 162,1620,162,1620,1620,162,1620,162 cycles, each slot 1890 cycles; done pulses once at cycle 15121; busy low after.
- Read, nbits=8, bus model pulls low during slots for a 0 in pattern 0x3C -> rdata=0x3C at done; each drive_low pulse is 162 cycles.
- nbits=0 start -> done at cycle 1; drive_low never asserts; rdata=0.
- start asserted at cycles 500 and 3000 during a 16-bit write -> ignored; exactly one done at cycle 16*1890+1.
- rst_n low at cycle 100 of a write-0 slot -> drive_low=0, busy=0 asynchronously; no done; next start runs normally.
- OW_STRONG_PULLUP_EN defined, write nbits=8 -> strong_pu high for 13500 cycles starting right after slot 8; done at cycle 15121+13500; read transaction shows no strong_pu.
